// File: rtl/palette_engine_pkg.sv
// Shared constants and types for the palette lookup engine: default colour
// table, fade unity level and the 12-bit rgb entry layout.
package palette_engine_pkg;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb12_t;

  localparam logic [4:0] FADE_UNITY      = 5'd16;
  localparam int         DEFAULT_ENTRIES = 16;

  localparam rgb12_t DEFAULT_TABLE [DEFAULT_ENTRIES] = '{
    12'h024, 12'hFE3, 12'hD5F, 12'h06F, 12'hF12, 12'hFFF, 12'h084, 12'h0CF,
    12'h30A, 12'h579, 12'hAE0, 12'h82E, 12'h1B0, 12'h702, 12'hF80, 12'hABC
  };

  // Entries beyond the built-in table reset to black.
  function automatic rgb12_t default_rgb12(input int idx);
    rgb12_t entry;
    if ((idx >= 0) && (idx < DEFAULT_ENTRIES)) begin
      entry = DEFAULT_TABLE[idx[3:0]];
    end else begin
      entry = 12'h000;
    end
    return entry;
  endfunction

endpackage

// File: rtl/palette_scale.sv
// One colour channel scaled by a 0..16 brightness level: (chan * level) >> 4,
// formed at CH_W+5 bits so level 16 reproduces the input exactly.
module palette_scale
  import palette_engine_pkg::*;
#(
  parameter int CH_W = 4
) (
  input  logic [CH_W-1:0] chan,
  input  logic [4:0]      level,
  output logic [CH_W-1:0] scaled
);

  logic [CH_W+4:0] prod_s;

  assign prod_s = {5'd0, chan} * {{CH_W{1'b0}}, level};
  assign scaled = CH_W'(prod_s >> 4);

endmodule

// File: rtl/palette_engine.sv
// Banked palette lookup with per-frame bank switch and brightness fade.
// Two-stage pipeline: stage 1 reads the entry, stage 2 scales it.
module palette_engine
  import palette_engine_pkg::*;
#(
  parameter  int IDX_W     = 4,
  parameter  int CH_W      = 4,
  parameter  int NUM_BANKS = 4,
  localparam int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                in_valid,
  input  logic [IDX_W-1:0]    index,
  input  logic                frame_start,
  input  logic [BANK_W-1:0]   bank_sel,
  input  logic [4:0]          fade_target,
  input  logic                wr_en,
  input  logic [BANK_W-1:0]   wr_bank,
  input  logic [IDX_W-1:0]    wr_index,
  input  logic [3*CH_W-1:0]   wr_rgb,
  output logic                out_valid,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue,
  output logic [BANK_W-1:0]   active_bank,
  output logic [4:0]          fade_level
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [3*CH_W-1:0] mem_r [NUM_BANKS][DEPTH];

  logic              s1_valid_r;
  logic [3*CH_W-1:0] s1_rgb_r;
  logic [4:0]        s1_level_r;

  logic [3*CH_W-1:0] rd_rgb_s;
  logic [4:0]        target_s;
  logic [4:0]        level_next_s;
  logic [CH_W-1:0]   scaled_red_s;
  logic [CH_W-1:0]   scaled_green_s;
  logic [CH_W-1:0]   scaled_blue_s;

  // Default entry resized to CH_W per channel (truncate or zero-extend).
  function automatic logic [3*CH_W-1:0] default_entry(input int idx);
    rgb12_t d;
    d = default_rgb12(idx);
    return {CH_W'(d.red), CH_W'(d.green), CH_W'(d.blue)};
  endfunction

  // Palette storage: full table reload on reset, one entry write per cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_r[b][i] <= default_entry(i);
        end
      end
    end else if (wr_en) begin
      mem_r[wr_bank][wr_index] <= wr_rgb;
    end
  end

  // Stage-1 read with write-through bypass for a same-cycle write to the same entry.
  always_comb begin
    rd_rgb_s = mem_r[active_bank][index];
    if (wr_en && (wr_bank == active_bank) && (wr_index == index)) begin
      rd_rgb_s = wr_rgb;
    end else begin
      rd_rgb_s = mem_r[active_bank][index];
    end
  end

  // Fade step: one unit toward the clamped target per frame.
  always_comb begin
    target_s     = fade_target;
    level_next_s = fade_level;
    if (fade_target > FADE_UNITY) begin
      target_s = FADE_UNITY;
    end else begin
      target_s = fade_target;
    end
    if (fade_level < target_s) begin
      level_next_s = fade_level + 5'd1;
    end else if (fade_level > target_s) begin
      level_next_s = fade_level - 5'd1;
    end else begin
      level_next_s = fade_level;
    end
  end

  // Bank and level only change at frame start; pixels in that cycle see old values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      active_bank <= {BANK_W{1'b0}};
      fade_level  <= FADE_UNITY;
    end else if (frame_start) begin
      active_bank <= bank_sel;
      fade_level  <= level_next_s;
    end
  end

  // Stage 1: capture entry and the level in effect for this pixel.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_r <= 1'b0;
      s1_rgb_r   <= {(3*CH_W){1'b0}};
      s1_level_r <= FADE_UNITY;
    end else begin
      s1_valid_r <= in_valid;
      s1_rgb_r   <= rd_rgb_s;
      s1_level_r <= fade_level;
    end
  end

  palette_scale #(.CH_W(CH_W)) u_scale_red (
    .chan   (s1_rgb_r[3*CH_W-1:2*CH_W]),
    .level  (s1_level_r),
    .scaled (scaled_red_s)
  );

  palette_scale #(.CH_W(CH_W)) u_scale_green (
    .chan   (s1_rgb_r[2*CH_W-1:CH_W]),
    .level  (s1_level_r),
    .scaled (scaled_green_s)
  );

  palette_scale #(.CH_W(CH_W)) u_scale_blue (
    .chan   (s1_rgb_r[CH_W-1:0]),
    .level  (s1_level_r),
    .scaled (scaled_blue_s)
  );

  // Stage 2: registered faded colour.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid <= 1'b0;
      red       <= {CH_W{1'b0}};
      green     <= {CH_W{1'b0}};
      blue      <= {CH_W{1'b0}};
    end else begin
      out_valid <= s1_valid_r;
      red       <= scaled_red_s;
      green     <= scaled_green_s;
      blue      <= scaled_blue_s;
    end
  end

endmodule

// File: tb/tb_palette_engine.sv
// Self-checking bench for palette_engine: directed scenarios followed by
// randomized traffic, all compared against a behavioural palette model.
module tb_palette_engine;

  localparam int IDX_W     = 4;
  localparam int CH_W      = 4;
  localparam int NUM_BANKS = 4;
  localparam int BANK_W    = $clog2(NUM_BANKS);

  logic              Clk;
  logic              Reset;
  logic              in_valid;
  logic [IDX_W-1:0]  index;
  logic              frame_start;
  logic [BANK_W-1:0] bank_sel;
  logic [4:0]        fade_target;
  logic              wr_en;
  logic [BANK_W-1:0] wr_bank;
  logic [IDX_W-1:0]  wr_index;
  logic [3*CH_W-1:0] wr_rgb;
  logic              out_valid;
  logic [CH_W-1:0]   red, green, blue;
  logic [BANK_W-1:0] active_bank;
  logic [4:0]        fade_level;

  palette_engine #(.IDX_W(IDX_W), .CH_W(CH_W), .NUM_BANKS(NUM_BANKS)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .index(index),
    .frame_start(frame_start), .bank_sel(bank_sel), .fade_target(fade_target),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_rgb(wr_rgb),
    .out_valid(out_valid), .red(red), .green(green), .blue(blue),
    .active_bank(active_bank), .fade_level(fade_level)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [11:0] def_tab [16] = '{12'h024, 12'hFE3, 12'hD5F, 12'h06F, 12'hF12, 12'hFFF,
                                12'h084, 12'h0CF, 12'h30A, 12'h579, 12'hAE0, 12'h82E,
                                12'h1B0, 12'h702, 12'hF80, 12'hABC};
  logic [11:0] m_mem [NUM_BANKS][16];
  int          m_bank  = 0;
  int          m_level = 16;
  logic        pend_v  = 1'b0;
  logic [11:0] pend_rgb = 12'h000;
  logic        exp_v, exp_rst;
  logic [11:0] exp_rgb;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] fade(input logic [11:0] c, input int lvl);
    int r, g, b;
    r = (int'(c[11:8]) * lvl) / 16;
    g = (int'(c[7:4])  * lvl) / 16;
    b = (int'(c[3:0])  * lvl) / 16;
    return {r[3:0], g[3:0], b[3:0]};
  endfunction

  // One clock: advance the model with the inputs seen at this edge, then compare.
  task automatic step();
    int tgt;
    @(posedge Clk);
    if (Reset) begin
      exp_rst = 1'b1;
      exp_v   = 1'b0;
      pend_v  = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++)
        for (int i = 0; i < 16; i++) m_mem[b][i] = def_tab[i];
      m_bank  = 0;
      m_level = 16;
    end else begin
      exp_rst = 1'b0;
      exp_v   = pend_v;
      exp_rgb = pend_rgb;
      if (wr_en) m_mem[wr_bank][wr_index] = wr_rgb;
      pend_v   = in_valid;
      pend_rgb = fade(m_mem[m_bank][index], m_level);
      if (frame_start) begin
        tgt = (fade_target > 5'd16) ? 16 : int'(fade_target);
        if (m_level < tgt) m_level++;
        else if (m_level > tgt) m_level--;
        m_bank = int'(bank_sel);
      end
    end
    #1;
    check_value("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
    if (exp_v) check_value("rgb", {20'd0, red, green, blue}, {20'd0, exp_rgb});
    if (exp_rst) check_value("rgb_reset", {20'd0, red, green, blue}, 32'd0);
    check_value("active_bank", {30'd0, active_bank}, m_bank);
    check_value("fade_level", {27'd0, fade_level}, m_level);
  endtask

  task automatic idle();
    in_valid = 1'b0; frame_start = 1'b0; wr_en = 1'b0;
    index = '0; wr_index = '0; wr_bank = '0; wr_rgb = '0;
  endtask

  task automatic pulses(input int n, input logic [BANK_W-1:0] bank, input logic [4:0] tgt);
    for (int k = 0; k < n; k++) begin
      frame_start = 1'b1; bank_sel = bank; fade_target = tgt;
      step();
    end
    frame_start = 1'b0;
  endtask

  task automatic lookup(input logic [IDX_W-1:0] idx);
    in_valid = 1'b1; index = idx;
    step();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    idle();
    bank_sel = '0; fade_target = 5'd16;
    Reset = 1'b1;
    repeat (3) step();
    check_value("reset_valid", {31'd0, out_valid}, 32'd0);
    check_value("reset_level", {27'd0, fade_level}, 32'd16);

    // First pixel after reset release
    Reset = 1'b0;
    lookup(4'd1);
    check_value("first_pixel_valid", {31'd0, out_valid}, 32'd1);
    check_value("first_pixel_rgb", {20'd0, red, green, blue}, 32'hFE3);

    // Bank switch picks up a freshly written entry; bank 0 untouched
    wr_en = 1'b1; wr_bank = 2'd2; wr_index = 4'd5; wr_rgb = 12'h123;
    step();
    idle();
    pulses(1, 2'd2, 5'd16);
    lookup(4'd5);
    check_value("bank2_rgb", {20'd0, red, green, blue}, 32'h123);
    pulses(1, 2'd0, 5'd16);
    lookup(4'd5);
    check_value("bank0_rgb", {20'd0, red, green, blue}, 32'hFFF);

    // Fade down to half brightness, then hold at target
    pulses(8, 2'd0, 5'd8);
    check_value("fade_level8", {27'd0, fade_level}, 32'd8);
    lookup(4'd5);
    check_value("fade_rgb", {20'd0, red, green, blue}, 32'h777);
    pulses(1, 2'd0, 5'd8);
    check_value("fade_hold", {27'd0, fade_level}, 32'd8);

    // Pixel alongside frame_start uses the pre-update bank and level
    pulses(8, 2'd0, 5'd31);
    wr_en = 1'b1; wr_bank = 2'd1; wr_index = 4'd4; wr_rgb = 12'h555;
    step();
    idle();
    in_valid = 1'b1; index = 4'd4;
    frame_start = 1'b1; bank_sel = 2'd1; fade_target = 5'd0;
    step();
    idle();
    step();
    check_value("old_bank_rgb", {20'd0, red, green, blue}, 32'hF12);
    check_value("new_level", {27'd0, fade_level}, 32'd15);

    // Same-cycle write and read of one entry returns the written value
    pulses(1, 2'd1, 5'd16);
    wr_en = 1'b1; wr_bank = 2'd1; wr_index = 4'd7; wr_rgb = 12'hABC;
    in_valid = 1'b1; index = 4'd7;
    step();
    idle();
    step();
    check_value("bypass_rgb", {20'd0, red, green, blue}, 32'hABC);

    // Continuous stream with a reset pulse in the middle
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      index = IDX_W'($urandom_range(0, 15));
      Reset = (c == 10);
      step();
      if (c == 10) check_value("stream_reset", {31'd0, out_valid}, 32'd0);
      if (c == 11) check_value("stream_discard", {31'd0, out_valid}, 32'd0);
      if (c == 12) check_value("stream_resume", {31'd0, out_valid}, 32'd1);
    end
    Reset = 1'b0;
    idle();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      Reset       = ($urandom_range(0, 79) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      index       = IDX_W'($urandom_range(0, 15));
      frame_start = ($urandom_range(0, 7) == 0);
      bank_sel    = BANK_W'($urandom_range(0, NUM_BANKS - 1));
      fade_target = 5'($urandom_range(0, 31));
      wr_en       = ($urandom_range(0, 2) == 0);
      wr_bank     = ($urandom_range(0, 1) == 0) ? active_bank : BANK_W'($urandom_range(0, NUM_BANKS - 1));
      wr_index    = ($urandom_range(0, 1) == 0) ? index : IDX_W'($urandom_range(0, 15));
      wr_rgb      = 12'($urandom_range(0, 4095));
      step();
    end
    Reset = 1'b0;
    idle();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/palette_engine.md
PALETTE_ENGINE -- requirements
Module: palette_engine

Interface
REQ-001 SHALL have parameter IDX_W, default 4, pixel index width (depth 2**IDX_W entries per bank).
REQ-002 SHALL have parameter CH_W, default 4, bits per colour channel.
REQ-003 SHALL have parameter NUM_BANKS, default 4, number of selectable palettes (power of two, >=2).
REQ-004 SHALL have ports: Clk  in  1  single clock; all logic on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  pixel lookup request.
REQ-007 index  in  IDX_W  palette index of requested pixel.
REQ-008 frame_start  in  1  one-cycle pulse at start of vertical blank.
REQ-009 bank_sel  in  clog2(NUM_BANKS)  requested palette bank.
REQ-010 fade_target  in  5  target brightness, 0..16 (16 = unity; values >16 treated as 16).
REQ-011 wr_en  in  1  palette entry write strobe.
REQ-012 wr_bank  in  clog2(NUM_BANKS)  bank being written.
REQ-013 wr_index  in  IDX_W  entry being written.
REQ-014 wr_rgb  in  3*CH_W  {red, green, blue} entry value.
REQ-015 out_valid  out  1  red/green/blue valid.
REQ-016 red, green, blue  out  CH_W each  faded colour.
REQ-017 active_bank  out  clog2(NUM_BANKS)  bank currently in use.
REQ-018 fade_level  out  5  current brightness 0..16.

Function
REQ-019 Lookup SHALL be a 2-stage pipeline: stage 1 reads entry [active_bank][index]; stage 2 scales; out_valid = in_valid delayed exactly 2 cycles.
REQ-020 Pipeline SHALL accept one request per cycle with no stalls; gaps in in_valid propagate as gaps in out_valid.
REQ-021 Each channel output SHALL equal (entry_channel * fade_level) >> 4, computed at full CH_W+5 width then truncated to CH_W; level 16 returns entry exactly, level 0 returns 0.
REQ-022 Bank and fade_level used for a pixel SHALL be those in effect on the cycle the pixel enters stage 1.
REQ-023 On frame_start, active_bank SHALL load bank_sel, visible from the following cycle.
REQ-024 On frame_start, fade_level SHALL move one step toward clamped fade_target (+1 if below, -1 if above, unchanged if equal), visible from the following cycle.
REQ-025 A pixel presented in the same cycle as frame_start SHALL use the pre-update bank and level.
REQ-026 Write SHALL update entry [wr_bank][wr_index] on the clock edge where wr_en=1; writes allowed any cycle, including during active video.
REQ-027 Simultaneous write and stage-1 read of the same bank/index SHALL return the newly written value (write-through bypass).
REQ-028 Writes to any other entry SHALL not disturb in-flight pipeline data.

Reset
REQ-029 While Reset=1: out_valid=0, red/green/blue=0, active_bank=0, fade_level=16, all pipeline valid bits cleared.
REQ-030 Reset SHALL load every bank with the default 16-colour table (bank-independent) for entries 0..15, entries >=16 to 0, each channel truncated/zero-extended to CH_W.
REQ-031 Default table {R,G,B} hex, entry 0..15: 024 FE3 D5F 06F F12 FFF 084 0CF 30A 579 AE0 82E 1B0 702 F80 ABC.
REQ-032 Reset asserted mid-pipeline SHALL discard in-flight pixels; first out_valid after release is 2 cycles after the first post-reset in_valid.

Structure
REQ-033 A shared package SHALL hold the default colour table constant, the fade unity constant (16) and the rgb struct typedef.
REQ-034 Per-channel scaling SHALL be one sub-module, palette_scale (CH_W param, entry channel and level in, scaled channel out), instantiated three times.

Verification
REQ-035 Reset release, in_valid=1, index=1 -> two cycles later out_valid=1, rgb=F,E,3.
REQ-036 Write bank 2 idx 5 = 0x123, bank_sel=2, frame_start pulse, then lookup idx 5 -> 1,2,3; bank 0 idx 5 still FFF.
REQ-037 fade_target=8, 8 frame_start pulses, lookup idx 5 -> fade_level 8, rgb=7,7,7; 9th pulse leaves level 8.
REQ-038 in_valid with index=4 in same cycle as frame_start changing bank/level -> pixel uses old bank and level=16 (F,1,2).
REQ-039 wr_en and in_valid same cycle, same bank/index, wr_rgb=0xABC -> output A,B,C two cycles later.
REQ-040 Back-to-back in_valid for 20 cycles with Reset pulsed at cycle 10 -> out_valid low from reset cycle until 2 cycles after first post-reset request; no stale pixel emitted.
